// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Purpose:
//    Sequences LC3 data-memory transactions for the MemAccess stage. One
//    load/store request (LD, LDR, LDI, ST, STR, STI) becomes one or two memory
//    accesses; LDI/STI first read an indirect pointer and then perform the
//    final access at the pointer address. Every access state is bounded by a
//    wait counter so a memory that never acknowledges aborts with err.
//
// Parameters:
//    TIMEOUT   max cycles an access state waits for dmem_ack (>= 2)
//    CNT_W     wait counter width, must be able to hold TIMEOUT
//
// Ports:
//    clock      in   rising-edge clock
//    reset      in   synchronous, active-low reset
//    start      in   request valid, only looked at while idle
//    opcode     in   [3:0] LC3 opcode of the request
//    M_addr     in   [15:0] effective address
//    M_data     in   [15:0] store data
//    DMem_dout  in   [15:0] memory read data, valid with dmem_ack
//    dmem_ack   in   memory completes the current access this cycle
//    DMem_addr  out  [15:0] memory address
//    DMem_din   out  [15:0] memory write data (0 unless writing)
//    DMem_rd    out  1 = read, 0 = write
//    memout     out  [15:0] final load data
//    mem_state  out  [1:0] 0=READ 1=WRITE 2=IND 3=IDLE
//    busy       out  high whenever mem_state is not IDLE
//    done       out  one-cycle pulse, request completed
//    err        out  one-cycle pulse, timeout or illegal opcode
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  opcode,
   input  logic [15:0] M_addr,
   input  logic [15:0] M_data,
   input  logic [15:0] DMem_dout,
   input  logic        dmem_ack,
   output logic [15:0] DMem_addr,
   output logic [15:0] DMem_din,
   output logic        DMem_rd,
   output logic [15:0] memout,
   output logic [1:0]  mem_state,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Encodings equal the externally visible mem_state values.
   typedef enum logic [1:0] {
      ST_READ  = 2'd0,
      ST_WRITE = 2'd1,
      ST_IND   = 2'd2,
      ST_IDLE  = 2'd3
   } state_t;

   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_STI = 4'b1011;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state_q, state_d;
   logic [15:0]       addr_q, addr_d;
   logic [15:0]       din_q, din_d;
   logic              rd_q, rd_d;
   logic [15:0]       memout_q, memout_d;
   logic [15:0]       data_q, data_d;
   logic              store_q, store_d;     // indirect request ends in a write
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         din_q    <= '0;
         rd_q     <= 1'b1;
         memout_q <= '0;
         data_q   <= '0;
         store_q  <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rd_q     <= rd_d;
         memout_q <= memout_d;
         data_q   <= data_d;
         store_q  <= store_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      din_d    = din_q;
      rd_d     = rd_q;
      memout_d = memout_q;
      data_d   = data_q;
      store_d  = store_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d = M_addr;
               data_d = M_data;
               cnt_d  = '0;
               case (opcode)
                  OP_LD, OP_LDR: begin
                     state_d = ST_READ;
                     rd_d    = 1'b1;
                  end
                  OP_ST, OP_STR: begin
                     state_d = ST_WRITE;
                     rd_d    = 1'b0;
                     din_d   = M_data;
                  end
                  OP_LDI, OP_STI: begin
                     state_d = ST_IND;
                     rd_d    = 1'b1;
                     store_d = opcode[0];
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end

         default: begin
            // IND / READ / WRITE share the ack-or-timeout structure; an ack
            // in the last allowed cycle takes priority over the timeout.
            if (dmem_ack) begin
               cnt_d = '0;
               case (state_q)
                  ST_IND: begin
                     addr_d = DMem_dout;
                     if (store_q) begin
                        state_d = ST_WRITE;
                        rd_d    = 1'b0;
                        din_d   = data_q;
                     end else begin
                        state_d = ST_READ;
                     end
                  end
                  ST_READ: begin
                     memout_d = DMem_dout;
                     done_d   = 1'b1;
                     state_d  = ST_IDLE;
                  end
                  default: begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                     rd_d    = 1'b1;
                     din_d   = '0;
                  end
               endcase
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
               rd_d    = 1'b1;
               din_d   = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
      endcase
   end

   assign DMem_addr = addr_q;
   assign DMem_din  = din_q;
   assign DMem_rd   = rd_q;
   assign memout    = memout_q;
   assign mem_state = state_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule
